// File: rtl/encoder_32_to_5_seq.sv
// Sequential 32-to-5 encoder: emits the index of each set bit of an accepted mask, one per handshake.
// Optional macro ENCODER_COUNT_EN adds a pop_count output tracking the indices still to be emitted.
module encoder_32_to_5_seq #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_mask,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_index,
   output logic        out_last,
   output logic        empty_pulse
`ifdef ENCODER_COUNT_EN
   ,
   output logic [5:0]  pop_count
`endif
);

   localparam int unsigned MASK_W = 32;
   localparam int unsigned IDX_W  = 5;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [MASK_W-1:0]  pending_q, pending_d;
   logic               empty_q, empty_d;
   logic [IDX_W-1:0]   sel_idx;
   logic               one_left;
   logic               accept;
   logic               handshake;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable && in_valid && (in_mask != '0)) state_d = ST_EMIT;
         ST_EMIT: if (enable && out_ready && one_left)       state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready  = 1'b1;
         ST_EMIT: out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Priority encode of pending; the last hit in the loop wins
   always_comb begin
      sel_idx = '0;
      if (LSB_FIRST) begin
         for (int i = MASK_W - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < MASK_W; i++) begin
            if (pending_q[i]) sel_idx = IDX_W'(i);
         end
      end
   end

   assign one_left  = (pending_q != '0) &&
                      ((pending_q & (pending_q - MASK_W'(1))) == '0);
   assign accept    = enable && in_valid && (state_q == ST_IDLE);
   assign handshake = enable && out_ready && (state_q == ST_EMIT);

   assign out_index   = sel_idx;
   assign out_last    = one_left;
   assign empty_pulse = empty_q;

   // Pending mask and empty-mask pulse; everything holds while enable is low
   always_comb begin
      pending_d = pending_q;
      empty_d   = empty_q;
      if (accept) begin
         pending_d = in_mask;
      end else if (handshake) begin
         pending_d = pending_q & ~(MASK_W'(1) << sel_idx);
      end
      if (enable) begin
         empty_d = accept && (in_mask == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         empty_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         empty_q   <= empty_d;
      end
   end

`ifdef ENCODER_COUNT_EN
   localparam int unsigned CNT_W = 6;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] m);
      logic [CNT_W-1:0] sum;
      sum = '0;
      for (int i = 0; i < MASK_W; i++) begin
         sum = sum + CNT_W'(m[i]);
      end
      return sum;
   endfunction

   // Remaining-index counter, loaded at accept
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = popcount(in_mask);
      end else if (handshake) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pop_count = cnt_q;
`endif

endmodule

// File: tb/tb_encoder_32_to_5_seq.sv
// Bench for encoder_32_to_5_seq: LSB-first and MSB-first instances driven in parallel.
// Build with ENCODER_COUNT_EN defined to also check pop_count.
module tb_encoder_32_to_5_seq;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic [31:0] in_mask;
   logic        out_ready;

   logic        l_in_ready, l_out_valid, l_out_last, l_empty;
   logic [4:0]  l_out_index;
   logic        m_in_ready, m_out_valid, m_out_last, m_empty;
   logic [4:0]  m_out_index;
`ifdef ENCODER_COUNT_EN
   logic [5:0]  l_pop, m_pop;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   encoder_32_to_5_seq #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (l_in_ready),
      .in_mask     (in_mask),
      .out_valid   (l_out_valid),
      .out_ready   (out_ready),
      .out_index   (l_out_index),
      .out_last    (l_out_last),
      .empty_pulse (l_empty)
`ifdef ENCODER_COUNT_EN
      ,
      .pop_count   (l_pop)
`endif
   );

   encoder_32_to_5_seq #(.LSB_FIRST(1'b0)) dut_msb (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (m_in_ready),
      .in_mask     (in_mask),
      .out_valid   (m_out_valid),
      .out_ready   (out_ready),
      .out_index   (m_out_index),
      .out_last    (m_out_last),
      .empty_pulse (m_empty)
`ifdef ENCODER_COUNT_EN
      ,
      .pop_count   (m_pop)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic        iv;
      logic [31:0] mask;
      logic        ordy;
      logic        chk;
      logic        ov;
      logic        ir;
      logic [4:0]  idx;
      logic        last;
      logic        ep;
      logic [4:0]  midx;
      logic        mlast;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic en, input logic iv,
                      input logic [31:0] mask, input logic ordy, input logic chk,
                      input logic ov, input logic ir, input logic [4:0] idx,
                      input logic last, input logic ep, input logic [4:0] midx,
                      input logic mlast);
      vec_t r;
      r.rst = rst; r.en = en; r.iv = iv; r.mask = mask; r.ordy = ordy;
      r.chk = chk; r.ov = ov; r.ir = ir; r.idx = idx; r.last = last;
      r.ep = ep; r.midx = midx; r.mlast = mlast;
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;

      // rst en iv mask ordy | chk ov ir idx last ep midx mlast
      add(1,0,0,32'h0,        0, 0,0,1, 0,0,0, 0,0);
      add(1,0,0,32'h0,        0, 1,0,1, 0,0,0, 0,0);
      add(0,1,1,32'h8000_0011,1, 1,0,1, 0,0,0, 0,0);
      add(0,1,1,32'hFFFF_FFFF,1, 1,1,0, 0,0,0,31,0);
      add(0,1,0,32'h0,        1, 1,1,0, 4,0,0, 4,0);
      add(0,1,0,32'h0,        1, 1,1,0,31,1,0, 0,1);
      add(0,1,1,32'h0000_0300,0, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        0, 1,1,0, 8,0,0, 9,0);
      add(0,1,0,32'h0,        0, 1,1,0, 8,0,0, 9,0);
      add(0,1,0,32'h0,        0, 1,1,0, 8,0,0, 9,0);
      add(0,1,0,32'h0,        1, 1,1,0, 8,0,0, 9,0);
      add(0,1,0,32'h0,        1, 1,1,0, 9,1,0, 8,1);
      add(0,1,1,32'h0,        0, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        0, 1,0,1, 0,0,1, 0,0);
      add(0,1,1,32'h0000_0006,1, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        1, 1,1,0, 1,0,0, 2,0);
      add(0,1,0,32'h0,        1, 1,1,0, 2,1,0, 1,1);
      add(0,1,1,32'h0,        0, 1,0,1, 0,0,0, 0,0);
      add(0,0,1,32'h1,        0, 1,0,1, 0,0,1, 0,0);
      add(0,0,1,32'h1,        0, 1,0,1, 0,0,1, 0,0);
      add(0,1,1,32'h1,        0, 1,0,1, 0,0,1, 0,0);
      add(0,0,0,32'h0,        1, 1,1,0, 0,1,0, 0,1);
      add(0,0,0,32'h0,        1, 1,1,0, 0,1,0, 0,1);
      add(0,1,0,32'h0,        1, 1,1,0, 0,1,0, 0,1);
      add(0,1,1,32'h0000_0F00,1, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        1, 1,1,0, 8,0,0,11,0);
      add(1,1,0,32'h0,        1, 1,1,0, 9,0,0,10,0);
      add(1,0,0,32'h0,        0, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        1, 1,0,1, 0,0,0, 0,0);
      add(0,1,0,32'h0,        1, 1,0,1, 0,0,0, 0,0);

      foreach (vecs[s]) begin
         @(negedge clk);
         if (vecs[s].chk) begin
            check($sformatf("s%0d out_valid", s),  32'(l_out_valid), 32'(vecs[s].ov));
            check($sformatf("s%0d in_ready", s),   32'(l_in_ready),  32'(vecs[s].ir));
            check($sformatf("s%0d out_index", s),  32'(l_out_index), 32'(vecs[s].idx));
            check($sformatf("s%0d out_last", s),   32'(l_out_last),  32'(vecs[s].last));
            check($sformatf("s%0d empty_pulse", s),32'(l_empty),     32'(vecs[s].ep));
            check($sformatf("s%0d msb out_valid", s), 32'(m_out_valid), 32'(vecs[s].ov));
            check($sformatf("s%0d msb out_index", s), 32'(m_out_index), 32'(vecs[s].midx));
            check($sformatf("s%0d msb out_last", s),  32'(m_out_last),  32'(vecs[s].mlast));
         end
         reset     = vecs[s].rst;
         enable    = vecs[s].en;
         in_valid  = vecs[s].iv;
         in_mask   = vecs[s].mask;
         out_ready = vecs[s].ordy;
      end

      // Full mask streamed at one index per cycle
      @(negedge clk);
      reset = 1'b0; enable = 1'b1; in_valid = 1'b1; in_mask = 32'hFFFF_FFFF; out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_mask  = '0;
         check($sformatf("full%0d out_valid", i), 32'(l_out_valid), 32'd1);
         check($sformatf("full%0d in_ready", i),  32'(l_in_ready),  32'd0);
         check($sformatf("full%0d out_index", i), 32'(l_out_index), 32'(i));
         check($sformatf("full%0d out_last", i),  32'(l_out_last),  32'(i == 31));
         check($sformatf("full%0d msb out_index", i), 32'(m_out_index), 32'(31 - i));
         check($sformatf("full%0d msb out_last", i),  32'(m_out_last),  32'(i == 31));
`ifdef ENCODER_COUNT_EN
         check($sformatf("full%0d pop_count", i), 32'(l_pop), 32'(32 - i));
         check($sformatf("full%0d msb pop_count", i), 32'(m_pop), 32'(32 - i));
`endif
      end
      @(negedge clk);
      check("full_end out_valid", 32'(l_out_valid), 32'd0);
      check("full_end in_ready",  32'(l_in_ready),  32'd1);
      check("full_end out_last",  32'(l_out_last),  32'd0);
`ifdef ENCODER_COUNT_EN
      check("full_end pop_count", 32'(l_pop), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/encoder_32_to_5_seq.md
Name: encoder_32_to_5_seq

Overview:
- Sequential encoder; the inverse of the register-file write-select decode.
- Accepts a 32-bit multi-hot register mask, e.g. pending-writeback or dirty bits, and emits the 5-bit index of each set bit, one per cycle, over a valid/ready handshake.
- Sits between a scoreboard/mask source and register-file read or flush sequencing logic.

Parameters:
- LSB_FIRST, 1, scan order: 1 emits lowest set index first, 0 emits highest first.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- enable  input  1  global advance; 0 freezes all state (stall).
- in_valid  input  1  mask offered.
- in_ready  output  1  block can accept a mask (IDLE state).
- in_mask  input  32  register mask; bit i = register i.
- out_valid  output  1  out_index valid.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  5  encoded register number.
- out_last  output  1  current index is the final set bit of the mask.
- empty_pulse  output  1  one-cycle pulse: accepted mask was all zeros.

Behaviour:
- Reset values (registered): state=IDLE, pending=32'h0, out_valid=0, empty_pulse=0. Consequently in_ready=1, out_index=0, out_last=0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on rising edge with enable & in_valid.
  - If in_mask != 0: pending<=in_mask, go to EMIT.
  - If in_mask == 0: empty_pulse=1 for exactly the next cycle, stay IDLE.
- EMIT:
  - in_ready=0; in_valid is ignored and the mask is not latched.
  - out_valid=1.
  - out_index = position of lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set bit of pending, decoded combinationally from the pending register.
  - out_last=1 when pending has exactly one bit set.
- Handshake:
  - On an edge with enable & out_valid & out_ready, clear the emitted bit in pending.
  - If out_last was 1, return to IDLE.
  - out_index and out_last hold stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Mask accepted at edge N gives out_valid=1 in cycle N+1.
  - Sustained throughput is one index per cycle with out_ready held 1.
  - Mask with k set bits occupies EMIT for k handshake cycles.
  - in_ready reasserts in the cycle after the last handshake, so the next accept is no earlier than edge N+k+1.
- enable=0: no state change, no accept, no handshake completion. Outputs hold their current values. empty_pulse, if high, stays high until the next enabled edge, then clears.
- Reset mid-EMIT: pending cleared and state=IDLE at that edge; out_valid=0 and in_ready=1 in the following cycle. Reset has priority over enable and all handshakes.
- Mask 32'hFFFFFFFF: 32 indices, 0..31 (LSB_FIRST=1) or 31..0; out_last only on the final index.
- Index wrap: none; out_index never exceeds 31.

Optional Feature:
- Macro: ENCODER_COUNT_EN.
- Defined:
  - Adds output pop_count [5:0], the population count of the accepted mask, registered at accept.
  - pop_count decrements on each completed handshake and holds 0 in IDLE.
  - Valid range 0..32; an accepted zero mask leaves pop_count=0.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset sequence: reset=1 for 2 cycles mid-EMIT of mask 32'h0000_0F00 -> after release out_valid=0, in_ready=1, pending discarded.
- LSB_FIRST=1, in_mask=32'h8000_0011, out_ready=1 -> out_index 0, 4, 31 on consecutive cycles; out_last=1 only with 31; in_ready=1 next cycle.
- LSB_FIRST=0, in_mask=32'h0000_0006 -> out_index 2 then 1; out_last on 1.
- Backpressure: mask 32'h0000_0300, out_ready=0 for 3 cycles -> out_index=8 held stable with out_valid=1; then out_ready=1 -> 8, 9.
- Zero mask: in_mask=0, in_valid=1 -> empty_pulse=1 for one cycle, out_valid stays 0, in_ready stays 1. Then enable=0 during EMIT of 32'h0000_0001 -> index 0 held, no completion until enable=1.
- ENCODER_COUNT_EN: mask 32'hFFFF_FFFF -> pop_count=32 after accept, 0 after 32 handshakes; all 32 indices emitted in order.
